// File: rtl/ddsm_frac_cfg_ctrl_if.sv
// Frequency-word handshake between the loop controller and ddsm_frac_cfg_ctrl.
// A word moves on a rising clock edge where cfg_valid and cfg_ready are both high.
interface ddsm_frac_cfg_ctrl_if #(
    parameter int INT_W = 8
);
    logic             cfg_valid;
    logic [INT_W-1:0] cfg_int;
    logic [3:0]       cfg_frac;
    logic             cfg_ready;

    modport master (output cfg_valid, cfg_int, cfg_frac, input  cfg_ready);
    modport slave  (input  cfg_valid, cfg_int, cfg_frac, output cfg_ready);
endinterface

// File: rtl/ddsm_frac_cfg_ctrl.sv
// Applies (N, fraction) words to a 4-bit first-order DDSM only at 16-cycle frame boundaries.
// It also forms the per-cycle divide ratio and checks each frame's ones-density against the fraction.
module ddsm_frac_cfg_ctrl #(
    parameter int INT_W         = 8,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    ddsm_frac_cfg_ctrl_if.slave  cfg,
    output logic                 ddsm_rst,
    output logic [3:0]           alpha_frac,
    input  logic                 seq_out,
    output logic [INT_W:0]       div_ratio,
    output logic                 locked,
    output logic                 seq_err
);

    typedef enum logic [2:0] {IDLE, PEND, RSTP, SETTLE, RUN} state_t;

    localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_FRAMES - 1);

    state_t           state;
    logic [INT_W-1:0] stage_int;
    logic [3:0]       stage_frac;
    logic [INT_W-1:0] n_reg;
    logic [3:0]       frame_cnt;
    logic [3:0]       settle_cnt;
    logic [4:0]       ones_cnt;
    logic             guard;

    logic             xfer;
    logic             frame_end;
    logic [4:0]       ones_total;
    logic [INT_W:0]   next_ratio;

    assign cfg.cfg_ready = (state == IDLE) || (state == RUN);
    assign ddsm_rst      = (state == IDLE) || (state == RSTP);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign frame_end     = (frame_cnt == 4'd15);
    assign ones_total    = ones_cnt + 5'(seq_out);
    assign next_ratio    = {1'b0, n_reg} + (INT_W+1)'(seq_out);

    // NOTE: every register here is assigned with <= so all of them see pre-edge values;
    // a blocking = would let later statements observe half-updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            stage_int  <= '0;
            stage_frac <= '0;
            n_reg      <= '0;
            alpha_frac <= '0;
            frame_cnt  <= '0;
            settle_cnt <= '0;
            ones_cnt   <= '0;
            guard      <= 1'b0;
            div_ratio  <= '0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_ratio <= '0;
                    locked    <= 1'b0;
                    if (xfer) state <= RSTP;
                end
                RSTP: begin
                    alpha_frac <= stage_frac;
                    n_reg      <= stage_int;
                    frame_cnt  <= '0;
                    ones_cnt   <= '0;
                    settle_cnt <= '0;
                    guard      <= 1'b1;
                    div_ratio  <= {1'b0, stage_int};
                    state      <= SETTLE;
                end
                SETTLE: begin
                    div_ratio <= next_ratio;
                    // The DDSM output is registered, so frame counting starts one cycle after release.
                    if (guard) begin
                        guard <= 1'b0;
                    end else begin
                        frame_cnt <= frame_cnt + 4'd1;
                        ones_cnt  <= frame_end ? 5'd0 : ones_total;
                        if (frame_end) begin
                            settle_cnt <= settle_cnt + 4'd1;
                            if (settle_cnt == LAST_SETTLE) begin
                                state  <= RUN;
                                locked <= 1'b1;
                            end
                        end
                    end
                end
                PEND, RUN: begin
                    div_ratio <= next_ratio;
                    frame_cnt <= frame_cnt + 4'd1;
                    ones_cnt  <= frame_end ? 5'd0 : ones_total;
                    if (frame_end && (ones_total != {1'b0, alpha_frac})) seq_err <= 1'b1;
                    if (state == PEND && frame_end) state <= RSTP;
                    if (state == RUN && xfer) begin
                        state  <= PEND;
                        locked <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new word clears the sticky error; the frame check of the old word no longer matters.
            if (xfer) begin
                stage_int  <= cfg.cfg_int;
                stage_frac <= cfg.cfg_frac;
                seq_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ddsm_frac_cfg_ctrl.sv
// Directed-plus-random bench for ddsm_frac_cfg_ctrl with a behavioural DDSM driving seq_out.
// Expected timing and densities come from frame arithmetic on recorded lock/transfer edges.
module tb_ddsm_frac_cfg_ctrl;

    localparam int INT_W         = 8;
    localparam int SETTLE_FRAMES = 2;
    localparam int LOCK_LAT      = 2 + 16 * SETTLE_FRAMES;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             seq_out = 1'b0;
    logic             ddsm_rst;
    logic [3:0]       alpha_frac;
    logic [INT_W:0]   div_ratio;
    logic             locked;
    logic             seq_err;

    ddsm_frac_cfg_ctrl_if #(.INT_W(INT_W)) bus ();

    ddsm_frac_cfg_ctrl #(
        .INT_W        (INT_W),
        .SETTLE_FRAMES(SETTLE_FRAMES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg       (bus),
        .ddsm_rst  (ddsm_rst),
        .alpha_frac(alpha_frac),
        .seq_out   (seq_out),
        .div_ratio (div_ratio),
        .locked    (locked),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         cyc       = 0;
    int         lock_edge = 0;
    int         xfer_edge = 0;
    int         sw_edge   = 0;
    logic       prev_seq  = 1'b0;
    logic       stuck     = 1'b0;
    logic [3:0] acc       = 4'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge advance the DDSM model that feeds the next rising edge.
    task automatic tick();
        logic [4:0] sum;
        @(negedge clk);
        cyc++;
        prev_seq = seq_out;
        if (ddsm_rst) begin
            acc = 4'd0;
            sum = 5'd0;
        end else begin
            sum = {1'b0, acc} + {1'b0, alpha_frac};
            acc = sum[3:0];
        end
        seq_out = stuck ? 1'b1 : sum[4];
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},    bus.cfg_ready, 1);
        check({tag, "_ddsm_rst"}, ddsm_rst,      1);
        check({tag, "_alpha"},    alpha_frac,    0);
        check({tag, "_div"},      div_ratio,     0);
        check({tag, "_locked"},   locked,        0);
        check({tag, "_seq_err"},  seq_err,       0);
    endtask

    task automatic send(input int n, input int f);
        bus.cfg_int   = INT_W'(n);
        bus.cfg_frac  = 4'(f);
        bus.cfg_valid = 1'b1;
        for (int i = 0; i < 200 && !bus.cfg_ready; i++) tick();
        check("send_ready", bus.cfg_ready, 1);
        tick();
        xfer_edge     = cyc;
        bus.cfg_valid = 1'b0;
    endtask

    // Lock is expected LOCK_LAT edges after the edge that entered RSTP.
    task automatic wait_lock(input string tag, input int from);
        for (int i = 0; i < 200 && !locked; i++) tick();
        check(tag, cyc - from, LOCK_LAT);
        lock_edge = cyc;
    endtask

    // Frame ends fall on lock_edge + 16m; the switch is the first one strictly after the transfer.
    task automatic wait_switch(input string tag, input int old_f, input int new_f);
        int s;
        s = lock_edge + 16 * ((xfer_edge - lock_edge) / 16 + 1);
        for (int i = 0; i < 64 && !ddsm_rst; i++) tick();
        check({tag, "_sw_edge"}, cyc, s);
        check({tag, "_old_alpha"}, alpha_frac, old_f);
        sw_edge = cyc;
        tick();
        check({tag, "_new_alpha"}, alpha_frac, new_f);
    endtask

    // Any 16 consecutive DDSM bits hold exactly f ones, so f samples read N+1 and the rest N.
    task automatic run_window(input int n, input int f, input string tag);
        int hi;
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check({tag, "_div"}, div_ratio, n + int'(prev_seq));
            if (div_ratio == (INT_W+1)'(n + 1)) hi++;
        end
        check({tag, "_density"}, hi, f);
    endtask

    task automatic goto_phase(input int p);
        for (int i = 0; i < 16 && ((cyc - lock_edge) % 16) != p; i++) tick();
    endtask

    initial begin
        int n;
        int f;
        int cur_f;
        int t;
        int hits;

        bus.cfg_valid = 1'b0;
        bus.cfg_int   = '0;
        bus.cfg_frac  = '0;
        #1 rst = 1'b1;
        #2;
        check_reset("reset");
        tick();
        rst = 1'b0;
        tick();

        // Bring-up from IDLE.
        send(10, 4);
        check("up_ready_low", bus.cfg_ready, 0);
        check("up_ddsm_rst_hi", ddsm_rst, 1);
        tick();
        check("up_alpha", alpha_frac, 4);
        check("up_ddsm_rst_lo", ddsm_rst, 0);
        wait_lock("up_lock", xfer_edge);
        for (int w = 0; w < 3; w++) run_window(10, 4, "up");
        check("up_seq_err", seq_err, 0);
        cur_f = 4;

        // Fraction sweep, reconfiguring from RUN at random frame phases (some on the frame-end edge).
        for (int fr = 1; fr < 16; fr++) begin
            goto_phase((fr % 5 == 0) ? 15 : int'($urandom_range(0, 15)));
            send(20, fr);
            check("sw_ready_low", bus.cfg_ready, 0);
            check("sw_unlock", locked, 0);
            wait_switch("sw", cur_f, fr);
            wait_lock("sw_lock", sw_edge);
            run_window(20, fr, "sw");
            check("sw_seq_err", seq_err, 0);
            cur_f = fr;
        end

        // Mid-frame offer with cfg_valid held high through PEND carrying a different word.
        goto_phase(5);
        bus.cfg_int   = INT_W'(33);
        bus.cfg_frac  = 4'd9;
        bus.cfg_valid = 1'b1;
        tick();
        t = cyc;
        check("mf_ready_low", bus.cfg_ready, 0);
        bus.cfg_int  = INT_W'(99);
        bus.cfg_frac = 4'd2;
        for (int i = 0; i < 40 && alpha_frac == 4'(cur_f); i++) tick();
        check("mf_hold_cycles", cyc - t, 11);
        check("mf_alpha", alpha_frac, 9);
        bus.cfg_valid = 1'b0;
        wait_lock("mf_lock", cyc - 1);
        run_window(33, 9, "mf");
        cur_f = 9;

        // seq_out stuck at 1 with frac=3: error at the first RUN frame end, sticky until a transfer.
        n = int'($urandom_range(1, 200));
        send(n, 3);
        wait_switch("st", cur_f, 3);
        stuck = 1'b1;
        wait_lock("st_lock", sw_edge);
        check("st_err_at_lock", seq_err, 0);
        repeat (15) tick();
        check("st_err_pre", seq_err, 0);
        check("st_div_stuck", div_ratio, n + 1);
        tick();
        check("st_err_set", seq_err, 1);
        repeat (20) tick();
        check("st_err_hold", seq_err, 1);
        stuck = 1'b0;
        repeat (40) tick();
        check("st_err_sticky", seq_err, 1);
        n = int'($urandom_range(0, 255));
        f = int'($urandom_range(1, 15));
        send(n, f);
        check("st_err_clear", seq_err, 0);
        wait_switch("st2", 3, f);
        wait_lock("st2_lock", sw_edge);
        run_window(n, f, "st2");
        check("st2_seq_err", seq_err, 0);
        cur_f = f;

        // Asynchronous reset while settling a new word.
        f = int'($urandom_range(0, 15));
        send(int'($urandom_range(0, 255)), f);
        wait_switch("rs", cur_f, f);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check_reset("rs_async");
        tick();
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (locked !== 1'b0) hits++;
        end
        check("rs_no_lock", hits, 0);
        check("rs_alpha_discarded", alpha_frac, 0);
        n = int'($urandom_range(0, 255));
        f = int'($urandom_range(1, 15));
        send(n, f);
        tick();
        wait_lock("rs_relock", xfer_edge);
        run_window(n, f, "rs");
        cur_f = f;

        // frac=0 with the largest N: div_ratio never moves off N.
        send(255, 0);
        wait_switch("z", cur_f, 0);
        wait_lock("z_lock", sw_edge);
        for (int w = 0; w < 2; w++) run_window(255, 0, "z");
        check("z_seq_err", seq_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddsm_frac_cfg_ctrl.md
# ddsm_frac_cfg_ctrl

Configuration controller for the fractional-N divider path. It accepts new (integer, fraction) frequency words over a valid/ready handshake and applies them to the 4-bit first-order DDSM sequence generator only at sequence-frame boundaries. It also holds the DDSM in reset across each update and forms the per-cycle divide ratio. It checks every 16-cycle frame of `seq_out` against the programmed fraction and reports settle and lock status to the loop.

## Interface
- `INT_W`, 8: width of the integer divide word.
- `SETTLE_FRAMES`, 2: number of complete 16-cycle frames after a DDSM restart before `locked` is asserted. Legal range is 1..15.

Ports (clock and reset first):
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  new frequency word offered.
- `cfg_int`  in  INT_W  integer part N.
- `cfg_frac`  in  4  fractional part; DDSM `alpha_frac` (0..15, in units of 1/16).
- `cfg_ready`  out  1  controller can accept a word.
- `ddsm_rst`  out  1  drives the DDSM `rst`.
- `alpha_frac`  out  4  drives the DDSM `alpha_frac`.
- `seq_out`  in  1  DDSM output bit.
- `div_ratio`  out  INT_W+1  registered N + `seq_out`.
- `locked`  out  1  configuration applied and settled.
- `seq_err`  out  1  sticky frame-density mismatch.

## Operation
- FSM states: IDLE, PEND, RSTP, SETTLE, RUN. Reset forces IDLE.
- Reset values: `cfg_ready`=1, `ddsm_rst`=1, `alpha_frac`=0, `div_ratio`=0, `locked`=0, `seq_err`=0. Internal `frame_cnt`, `ones_cnt`, `settle_cnt` and staging registers are all 0.
- A transfer occurs on a rising edge with `cfg_valid` && `cfg_ready`. On a transfer, `cfg_int` and `cfg_frac` are latched into staging and `seq_err` is cleared.
- `cfg_ready` = 1 only in IDLE and RUN.
- `ddsm_rst` = 1 in IDLE and RSTP, decoded from the state register.
- IDLE: on transfer, go to RSTP.
- RUN: on transfer, go to PEND and drop `locked`. The old word stays applied.
- PEND: wait for `frame_cnt`==15, then go to RSTP on that edge. `cfg_valid` is ignored in this state.
- RSTP (exactly 1 cycle):
  - `alpha_frac` and the internal N register load from staging.
  - `frame_cnt`, `ones_cnt` and `settle_cnt` clear.
  - Next state is SETTLE.
- SETTLE:
  - `frame_cnt` counts 0..15 and wraps.
  - At each wrap, `settle_cnt` increments.
  - When a wrap occurs with `settle_cnt`==SETTLE_FRAMES-1, go to RUN and set `locked`=1.
- RUN/PEND density check:
  - `ones_cnt` (5-bit) accumulates `seq_out` over each frame.
  - At `frame_cnt`==15, the total including the current bit is compared to `alpha_frac`.
  - On inequality, set `seq_err`=1. It is sticky until the next transfer.
  - `ones_cnt` then restarts.
  - The check is valid at any phase because a first-order 4-bit DDSM emits exactly `alpha_frac` ones in any 16 consecutive cycles.
- `div_ratio`:
  - Registered each cycle in SETTLE, PEND and RUN as zero-extended N + `seq_out`. It cannot overflow because the width is INT_W+1.
  - Holds N in RSTP.
  - Is 0 in IDLE.
- `alpha_frac`=0 is legal: `div_ratio`==N constantly and the expected ones count is 0.

## Timing
- Transfer from IDLE at edge k:
  - RSTP is active in cycle k+1, with `ddsm_rst`=1 and `cfg_ready`=0.
  - `alpha_frac` is valid from edge k+1.
  - SETTLE starts at edge k+2.
  - `locked` rises at edge k+2+16·SETTLE_FRAMES.
- Transfer in RUN: the switch happens at the first `frame_cnt`==15 edge after the transfer. If that edge is the transfer edge itself, the switch happens on the next wrap, 16 cycles later. The old fraction is never truncated mid-frame.
- `div_ratio` lags `seq_out` by one cycle.
- `seq_err` updates on the frame-end edge.
- Async `rst` mid-operation: all outputs return to reset values immediately, without waiting for a clock. A pending word is discarded.
- `cfg_valid` held high in RUN after a transfer causes no second transfer, because `cfg_ready`=0 until RUN is re-entered.

## Test plan
- Reset, then transfer N=10, frac=4 → `ddsm_rst` high for 1 cycle after the handshake, `alpha_frac`=4, `locked` at 34 cycles after the transfer. Each following 16-cycle window of `div_ratio` shows four 11s and twelve 10s, and `seq_err`=0.
- Sweep frac 1..15 with N=20, re-configuring from RUN each time → `alpha_frac` changes only one cycle after a `frame_cnt`==15 edge, and `seq_err` stays 0.
- Offer a new word mid-frame in RUN (frame_cnt=5) → `cfg_ready` falls, the old `alpha_frac` holds for 11 more cycles, then RSTP occurs.
- Force `seq_out` stuck at 1 with frac=3 → `seq_err`=1 at the first RUN frame end, remaining set until the next transfer clears it.
- Assert `rst` during SETTLE → all outputs go to reset values asynchronously. `locked` stays 0 until a new transfer plus 34 cycles.
- frac=0, N=255 → `div_ratio` is constantly 255 after SETTLE, and `seq_err`=0.
